axis_elastic_buffer: RTL
========================

AXIS_ELASTIC_BUFFER -- requirements
Module: axis_elastic_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, tdata width in bits (>=1).
REQ-002 The block SHALL have parameter USER_WIDTH, default 1, tuser width in bits (>=1).
REQ-003 The block SHALL have parameter DEPTH, default 4, total storage entries; legal values are powers of two >=2.
REQ-004 The block SHALL have parameter ALMOST_FULL, default DEPTH-1, occupancy threshold for almost_full (1..DEPTH).
REQ-005 The block SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 The block SHALL have port arstn, input, 1, reset, synchronous, active-low.
REQ-007 The block SHALL have port s_axis_tdata, input, DATA_WIDTH, input payload.
REQ-008 The block SHALL have port s_axis_tvalid, input, 1, input valid.
REQ-009 The block SHALL have port s_axis_tready, output, 1, input ready, driven directly from a flop.
REQ-010 The block SHALL have port s_axis_tlast, input, 1, input end of frame.
REQ-011 The block SHALL have port s_axis_tuser, input, USER_WIDTH, input sideband.
REQ-012 The block SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1, driven directly from a flop), m_axis_tready (input, 1), m_axis_tlast (output, 1) and m_axis_tuser (output, USER_WIDTH), forming the output stream.
REQ-013 The block SHALL have port occupancy, output, $clog2(DEPTH)+1, number of stored entries.
REQ-014 The block SHALL have port almost_full, output, 1, high when occupancy >= ALMOST_FULL.

Function
REQ-015 Push SHALL occur on a cycle with s_axis_tvalid && s_axis_tready; pop SHALL occur on a cycle with m_axis_tvalid && m_axis_tready.
REQ-016 Entries SHALL be delivered in strict FIFO order, with tdata, tlast and tuser kept together per entry.
REQ-017 Latency SHALL be one cycle: a word pushed at edge N into an empty buffer SHALL appear with m_axis_tvalid=1 after edge N.
REQ-018 The count SHALL update as follows: push only adds 1, pop only subtracts 1, and push plus pop together leaves it unchanged.
REQ-019 s_axis_tready SHALL be registered as (count_next < DEPTH); there SHALL be no combinational path from m_axis_tready to s_axis_tready.
REQ-020 When full (count==DEPTH), s_axis_tready SHALL be 0 even if a pop occurs in the same cycle; it SHALL rise the cycle after that pop.
REQ-021 m_axis_tvalid SHALL be 1 exactly when count>0; when empty, no entry SHALL be presented and the output payload is don't-care.
REQ-022 Output payload SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 With DEPTH>=2 and a continuous source and sink, throughput SHALL be one word per cycle with no bubbles.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH without a discontinuity in data order.
REQ-025 A push while empty and a simultaneous pop SHALL be impossible, because m_axis_tvalid=0; the pushed word SHALL be stored.
REQ-026 Storage SHALL be inferable as distributed RAM or flops; the storage array SHALL need no reset.

Reset
REQ-027 On arstn=0 at a clock edge, the block SHALL clear count, pointers, s_axis_tready, m_axis_tvalid, occupancy and almost_full to 0, discarding stored data.
REQ-028 s_axis_tready SHALL rise on the first edge with arstn=1; reset asserted mid-transfer SHALL drop all entries without emitting partial data.

Configuration
REQ-029 When macro AXIS_ELASTIC_STATUS_EN is defined, occupancy SHALL equal count and almost_full SHALL follow REQ-014, both registered and updated on the same edge as count.
REQ-030 When AXIS_ELASTIC_STATUS_EN is undefined, occupancy and almost_full SHALL be tied to 0, and the data path SHALL behave identically to the defined case.

Verification
REQ-031 The bench SHALL cover: reset, then push 0x11 with m_axis_tready=1 -> m_axis_tvalid=1 with tdata=0x11 one cycle later, then valid=0.
REQ-032 The bench SHALL cover: DEPTH=4, sink stalled, push 0xA0..0xA3 -> s_axis_tready=0 after the 4th push, occupancy=4, almost_full=1 from occupancy 3.
REQ-033 The bench SHALL cover: full buffer with m_axis_tready pulsed for 1 cycle -> 0xA0 popped, s_axis_tready=1 on the next cycle (not the same cycle).
REQ-034 The bench SHALL cover: 20 words 0x00..0x13 streamed with source and sink always ready -> 20 consecutive output cycles, in order, pointers wrapped 5 times.
REQ-035 The bench SHALL cover: random tvalid/tready at 50% with tlast on every 3rd word and tuser=word[0] -> output sequence, tlast and tuser match a reference queue.
REQ-036 The bench SHALL cover: arstn=0 with occupancy=3 -> next cycle m_axis_tvalid=0, occupancy=0; with the macro undefined, occupancy stays 0 throughout.

Source files
------------

// File: rtl/axis_elastic_buffer.sv
// AXI-Stream elastic buffer: DEPTH-entry FIFO with registered ready/valid and one-cycle latency.
// Optional status outputs (occupancy, almost_full) enabled by macro AXIS_ELASTIC_STATUS_EN.
module axis_elastic_buffer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALMOST_FULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       almost_full
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CntW   = AddrW + 1;
  localparam int unsigned EntryW = DATA_WIDTH + USER_WIDTH + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_bad_afull
    $error("ALMOST_FULL must be in 1..DEPTH");
  end

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              push, pop;

  assign push = s_axis_tvalid && s_ready_q;
  assign pop  = m_valid_q && m_axis_tready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
    // Both flags come from count_d so neither output has a combinational input path.
    s_ready_d = (count_d < DepthC);
    m_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  end

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;

`ifdef AXIS_ELASTIC_STATUS_EN
  localparam logic [CntW-1:0] AfullC = CntW'(ALMOST_FULL);
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (!arstn) almost_full_q <= 1'b0;
    else        almost_full_q <= (count_d >= AfullC);
  end

  assign occupancy   = count_q;
  assign almost_full = almost_full_q;
`else
  assign occupancy   = '0;
  assign almost_full = 1'b0;
`endif

endmodule
